// File: rtl/combat_pkg.sv
// Shared encodings for the fighting-game players and the hit resolver:
// player state codes, round state, winner, and box-normalisation helpers.
package combat_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_WALK_FWD     = 4'd1,
        ST_WALK_BACK    = 4'd2,
        ST_ATTACK_START = 4'd3,
        ST_ATTACK_END   = 4'd4,
        ST_ATTACK_PULL  = 4'd5
    } player_state_e;

    typedef enum logic [1:0] {
        RS_READY = 2'd0,
        RS_FIGHT = 2'd1,
        RS_KO    = 2'd2
    } round_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_e;

    localparam int COORD_W  = 10;
    localparam int HEALTH_W = 8;

    function automatic logic [COORD_W-1:0] min_c(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [COORD_W-1:0] max_c(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Inclusive overlap test of two axis-aligned boxes whose corners may be given
// in either order on each axis.
module box_overlap
    import combat_pkg::*;
(
    input  logic [COORD_W-1:0] a_x1,
    input  logic [COORD_W-1:0] a_x2,
    input  logic [COORD_W-1:0] a_y1,
    input  logic [COORD_W-1:0] a_y2,
    input  logic [COORD_W-1:0] b_x1,
    input  logic [COORD_W-1:0] b_x2,
    input  logic [COORD_W-1:0] b_y1,
    input  logic [COORD_W-1:0] b_y2,
    output logic               overlap
);

    logic x_ok;
    logic y_ok;

    assign x_ok = (min_c(a_x1, a_x2) <= max_c(b_x1, b_x2)) &&
                  (min_c(b_x1, b_x2) <= max_c(a_x1, a_x2));
    assign y_ok = (min_c(a_y1, a_y2) <= max_c(b_y1, b_y2)) &&
                  (min_c(b_y1, b_y2) <= max_c(a_y1, a_y2));
    assign overlap = x_ok && y_ok;

endmodule

// File: rtl/hit_resolver.sv
// Resolves hitbox/hurtbox contacts between two players, owning health, hitstun
// and the READY/FIGHT/KO round flow.
module hit_resolver
    import combat_pkg::*;
#(
    parameter int MAX_HEALTH  = 100,
    parameter int DAMAGE      = 10,
    parameter int STUN_CYCLES = 12,
    parameter int START_DELAY = 60,
    parameter int KO_HOLD     = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          p1_state,
    input  logic [3:0]          p2_state,
    input  logic [COORD_W-1:0]  p1_hit_x1,
    input  logic [COORD_W-1:0]  p1_hit_x2,
    input  logic [COORD_W-1:0]  p1_hit_y1,
    input  logic [COORD_W-1:0]  p1_hit_y2,
    input  logic [COORD_W-1:0]  p2_hit_x1,
    input  logic [COORD_W-1:0]  p2_hit_x2,
    input  logic [COORD_W-1:0]  p2_hit_y1,
    input  logic [COORD_W-1:0]  p2_hit_y2,
    input  logic [COORD_W-1:0]  p1_hurt_x1,
    input  logic [COORD_W-1:0]  p1_hurt_x2,
    input  logic [COORD_W-1:0]  p1_hurt_y1,
    input  logic [COORD_W-1:0]  p1_hurt_y2,
    input  logic [COORD_W-1:0]  p2_hurt_x1,
    input  logic [COORD_W-1:0]  p2_hurt_x2,
    input  logic [COORD_W-1:0]  p2_hurt_y1,
    input  logic [COORD_W-1:0]  p2_hurt_y2,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_hit,
    output logic                p2_hit,
    output logic                p1_stun,
    output logic                p2_stun,
    output logic [1:0]          round_state,
    output logic [1:0]          winner
);

    localparam int RC_MAX = (START_DELAY > KO_HOLD) ? START_DELAY : KO_HOLD;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam int SC_W   = $clog2(STUN_CYCLES + 1);

    round_state_e        round_q, round_d;
    winner_e             winner_q, winner_d;
    logic [RC_W-1:0]     rcnt_q, rcnt_d;
    logic [SC_W-1:0]     stun1_q, stun1_d, stun2_q, stun2_d;
    logic [HEALTH_W-1:0] health1_q, health1_d, health2_q, health2_d;
    logic                hit1_q, hit1_d, hit2_q, hit2_d;
    logic                landed1_q, landed1_d, landed2_q, landed2_d;

    logic ovl_p1_on_p2, ovl_p2_on_p1;
    logic act1, act2;
    logic hit_on_p1, hit_on_p2;

    box_overlap u_ovl_p1_on_p2 (
        .a_x1(p1_hit_x1), .a_x2(p1_hit_x2), .a_y1(p1_hit_y1), .a_y2(p1_hit_y2),
        .b_x1(p2_hurt_x1), .b_x2(p2_hurt_x2), .b_y1(p2_hurt_y1), .b_y2(p2_hurt_y2),
        .overlap(ovl_p1_on_p2)
    );

    box_overlap u_ovl_p2_on_p1 (
        .a_x1(p2_hit_x1), .a_x2(p2_hit_x2), .a_y1(p2_hit_y1), .a_y2(p2_hit_y2),
        .b_x1(p1_hurt_x1), .b_x2(p1_hurt_x2), .b_y1(p1_hurt_y1), .b_y2(p1_hurt_y2),
        .overlap(ovl_p2_on_p1)
    );

    assign act1 = (p1_state == ST_ATTACK_END);
    assign act2 = (p2_state == ST_ATTACK_END);

    // The landed latch limits each swing to a single hit.
    assign hit_on_p2 = act1 && ovl_p1_on_p2 && (round_q == RS_FIGHT) && !landed1_q;
    assign hit_on_p1 = act2 && ovl_p2_on_p1 && (round_q == RS_FIGHT) && !landed2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q   <= RS_READY;
            winner_q  <= WIN_NONE;
            rcnt_q    <= '0;
            stun1_q   <= '0;
            stun2_q   <= '0;
            health1_q <= HEALTH_W'(MAX_HEALTH);
            health2_q <= HEALTH_W'(MAX_HEALTH);
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
            landed1_q <= 1'b0;
            landed2_q <= 1'b0;
        end else begin
            round_q   <= round_d;
            winner_q  <= winner_d;
            rcnt_q    <= rcnt_d;
            stun1_q   <= stun1_d;
            stun2_q   <= stun2_d;
            health1_q <= health1_d;
            health2_q <= health2_d;
            hit1_q    <= hit1_d;
            hit2_q    <= hit2_d;
            landed1_q <= landed1_d;
            landed2_q <= landed2_d;
        end
    end

    always_comb begin
        round_d   = round_q;
        winner_d  = winner_q;
        rcnt_d    = rcnt_q;
        health1_d = health1_q;
        health2_d = health2_q;
        hit1_d    = 1'b0;
        hit2_d    = 1'b0;
        stun1_d   = (stun1_q != '0) ? stun1_q - 1'b1 : '0;
        stun2_d   = (stun2_q != '0) ? stun2_q - 1'b1 : '0;
        landed1_d = act1 && (landed1_q || hit_on_p2);
        landed2_d = act2 && (landed2_q || hit_on_p1);

        unique case (round_q)
            RS_READY: begin
                if (rcnt_q == RC_W'(START_DELAY - 1)) begin
                    round_d = RS_FIGHT;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            RS_FIGHT: begin
                if (hit_on_p2) begin
                    hit2_d    = 1'b1;
                    stun2_d   = SC_W'(STUN_CYCLES);
                    health2_d = (health2_q > HEALTH_W'(DAMAGE)) ?
                                health2_q - HEALTH_W'(DAMAGE) : '0;
                end
                if (hit_on_p1) begin
                    hit1_d    = 1'b1;
                    stun1_d   = SC_W'(STUN_CYCLES);
                    health1_d = (health1_q > HEALTH_W'(DAMAGE)) ?
                                health1_q - HEALTH_W'(DAMAGE) : '0;
                end
                if (health1_d == '0 || health2_d == '0) begin
                    round_d = RS_KO;
                    rcnt_d  = '0;
                    if (health1_d == '0 && health2_d == '0) winner_d = WIN_DRAW;
                    else if (health2_d == '0)               winner_d = WIN_P1;
                    else                                    winner_d = WIN_P2;
                end
            end
            RS_KO: begin
                if (rcnt_q == RC_W'(KO_HOLD - 1)) begin
                    round_d   = RS_READY;
                    rcnt_d    = '0;
                    health1_d = HEALTH_W'(MAX_HEALTH);
                    health2_d = HEALTH_W'(MAX_HEALTH);
                    winner_d  = WIN_NONE;
                    landed1_d = 1'b0;
                    landed2_d = 1'b0;
                    stun1_d   = '0;
                    stun2_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                round_d = RS_READY;
                rcnt_d  = '0;
            end
        endcase
    end

    assign p1_health   = health1_q;
    assign p2_health   = health2_q;
    assign p1_hit      = hit1_q;
    assign p2_hit      = hit2_q;
    assign p1_stun     = (stun1_q != '0);
    assign p2_stun     = (stun2_q != '0);
    assign round_state = round_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench for hit_resolver: stimulus pushes expected hit results,
// a negedge monitor pops and compares whenever a hit pulse appears.
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [7:0] p1_health, p2_health;
    logic       p1_hit, p2_hit, p1_stun, p2_stun;
    logic [1:0] round_state, winner;

    typedef struct packed {
        logic       h1;
        logic       h2;
        logic [7:0] hp1;
        logic [7:0] hp2;
        logic [1:0] rs;
        logic [1:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   e1 = 100;
    int   e2 = 100;

    always #5 clk = ~clk;

    hit_resolver dut (
        .clk(clk), .rst(rst), .p1_state(p1_state), .p2_state(p2_state),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_health(p1_health), .p2_health(p2_health), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_stun(p1_stun), .p2_stun(p2_stun), .round_state(round_state), .winner(winner)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dmg(input int h);
        return (h > 10) ? h - 10 : 0;
    endfunction

    // Push the expected outcome of one hit edge; the model tracks health.
    task automatic push_hit(input logic on_p1, input logic on_p2);
        exp_t e;
        if (on_p1) e1 = dmg(e1);
        if (on_p2) e2 = dmg(e2);
        e.h1  = on_p1;
        e.h2  = on_p2;
        e.hp1 = 8'(e1);
        e.hp2 = 8'(e2);
        e.rs  = (e1 == 0 || e2 == 0) ? 2'd2 : 2'd1;
        e.w   = (e1 == 0 && e2 == 0) ? 2'd3 : (e2 == 0) ? 2'd1 : (e1 == 0) ? 2'd2 : 2'd0;
        exp_q.push_back(e);
    endtask

    // One-cycle ATTACK_END swing by the selected attackers, followed by ATTACK_PULL.
    task automatic swing(input logic a1, input logic a2, input logic expect_hit);
        if (a1) p1_state = 4'd4;
        if (a2) p2_state = 4'd4;
        if (expect_hit) push_hit(a2, a1);
        step();
        if (a1) p1_state = 4'd5;
        if (a2) p2_state = 4'd5;
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (p1_hit || p2_hit) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_hit: got p1_hit=%0d p2_hit=%0d, expected no pulse",
                             p1_hit, p2_hit);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_p1", int'(p1_hit), int'(e.h1));
                    chk("pulse_p2", int'(p2_hit), int'(e.h2));
                    chk("health_p1", int'(p1_health), int'(e.hp1));
                    chk("health_p2", int'(p2_health), int'(e.hp2));
                    chk("round_state_at_hit", int'(round_state), int'(e.rs));
                    chk("winner_at_hit", int'(winner), int'(e.w));
                end
            end
        end
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        p1_state = 4'd0;  p2_state = 4'd0;
        p1_hit_x1 = 10'd247; p1_hit_x2 = 10'd323; p1_hit_y1 = 10'd194; p1_hit_y2 = 10'd227;
        p2_hurt_x1 = 10'd346; p2_hurt_x2 = 10'd297; p2_hurt_y1 = 10'd170; p2_hurt_y2 = 10'd320;
        p2_hit_x1 = 10'd280; p2_hit_x2 = 10'd250; p2_hit_y1 = 10'd200; p2_hit_y2 = 10'd220;
        p1_hurt_x1 = 10'd200; p1_hurt_x2 = 10'd260; p1_hurt_y1 = 10'd170; p1_hurt_y2 = 10'd320;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_p1_health", int'(p1_health), 100);
        chk("rst_p2_health", int'(p2_health), 100);
        chk("rst_round", int'(round_state), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_stun", int'({p1_stun, p2_stun}), 0);
        chk("rst_pulse", int'({p1_hit, p2_hit}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // READY lasts START_DELAY edges
        n = 0;
        while (round_state != 2'd1 && n < 200) begin step(); n++; end
        chk("ready_to_fight_edges", n, 60);
        chk("fight_winner", int'(winner), 0);

        // Single hit on P2 with reversed-x hurtbox, stun length
        p1_state = 4'd4;
        push_hit(1'b0, 1'b1);
        step();
        p1_state = 4'd5;
        n = 0;
        while (p2_stun && n < 50) begin step(); n++; end
        chk("p2_stun_cycles", n, 12);
        chk("p1_stun_untouched", int'(p1_stun), 0);

        // Held ATTACK_END lands once; re-entering lands again
        p1_state = 4'd4;
        push_hit(1'b0, 1'b1);
        step(); step();
        p1_state = 4'd5;
        step();
        p1_state = 4'd4;
        push_hit(1'b0, 1'b1);
        step();
        p1_state = 4'd5;
        step();
        chk("p2_health_after_reswing", int'(p2_health), 70);

        // Hurtbox just past the hitbox edge misses, touching edge hits
        p2_hurt_x1 = 10'd324; p2_hurt_x2 = 10'd373;
        swing(1'b1, 1'b0, 1'b0);
        chk("p2_health_no_overlap", int'(p2_health), 70);
        p2_hurt_x1 = 10'd323;
        swing(1'b1, 1'b0, 1'b1);
        p2_hurt_x1 = 10'd346; p2_hurt_x2 = 10'd297;

        // P2 attacks P1
        swing(1'b0, 1'b1, 1'b1);
        chk("p1_health_after_p2_hit", int'(p1_health), 90);

        // Drive both to 10, then simultaneous KO
        repeat (5) swing(1'b1, 1'b1, 1'b1);
        repeat (3) swing(1'b0, 1'b1, 1'b1);
        chk("p1_health_pre_ko", int'(p1_health), 10);
        chk("p2_health_pre_ko", int'(p2_health), 10);
        swing(1'b1, 1'b1, 1'b1);
        chk("ko_round_state", int'(round_state), 2);
        chk("ko_winner", int'(winner), 3);

        // KO ignores attacks and holds KO_HOLD edges
        p1_state = 4'd4;
        p2_state = 4'd4;
        n = 1;
        while (round_state == 2'd2 && n < 300) begin step(); n++; end
        chk("ko_hold_edges", n, 120);
        chk("ready_p1_health", int'(p1_health), 100);
        chk("ready_p2_health", int'(p2_health), 100);
        chk("ready_winner", int'(winner), 0);
        chk("ready_round", int'(round_state), 0);
        p1_state = 4'd0;
        p2_state = 4'd0;
        e1 = 100;
        e2 = 100;
        n = 0;
        while (round_state != 2'd1 && n < 200) begin step(); n++; end
        chk("second_ready_edges", n, 60);

        // Reset mid-round discards damage
        repeat (6) swing(1'b0, 1'b1, 1'b1);
        chk("p1_health_before_rst", int'(p1_health), 40);
        chk("p1_stun_before_rst", int'(p1_stun), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_p1_health", int'(p1_health), 100);
        chk("midrst_p2_health", int'(p2_health), 100);
        chk("midrst_round", int'(round_state), 0);
        chk("midrst_stun", int'({p1_stun, p2_stun}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        chk("pending_expected_hits", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
